// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification for seq_alu.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ID   = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_LHI  = 4'd10;
  localparam logic [3:0] OP_LRS  = 4'd11;
  localparam logic [3:0] OP_ARS  = 4'd12;
  localparam logic [3:0] OP_RR   = 4'd13;
  localparam logic [3:0] OP_ALS  = 4'd14;
  localparam logic [3:0] OP_ALR  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_LRS, OP_ARS, OP_RR, OP_ALS, OP_ALR: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_alu_alu_unit.sv
// Combinational single-step datapath: logic ops, add/sub with carry, and one-bit shift/rotate.
module alu_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Carry/borrow are taken from the extra top bit of the WIDTH+1 result.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff_s = {1'b0, a} - ({1'b0, b} + {{WIDTH{1'b0}}, cin});
  end

  // Opcode decode; shift ops move the operand by exactly one position.
  always_comb begin
    res  = a;
    cout = 1'b0;
    case (op)
      OP_ADD:  begin res = sum_s[WIDTH-1:0];  cout = sum_s[WIDTH];  end
      OP_SUB:  begin res = diff_s[WIDTH-1:0]; cout = diff_s[WIDTH]; end
      OP_ID:   res = a;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LHI:  res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_LRS:  res = {1'b0, a[WIDTH-1:1]};
      OP_ARS:  res = {a[WIDTH-1], a[WIDTH-1:1]};
      OP_RR:   res = {a[0], a[WIDTH-1:1]};
      OP_ALS:  res = {a[WIDTH-2:0], 1'b0};
      OP_ALR:  res = {a[WIDTH-2:0], a[WIDTH-1]};
      default: res = a;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake, iterative one-bit-per-cycle shifter, registered result and flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             Cout,
  output logic             Zero,
  output logic             Neg
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;

  logic [WIDTH-1:0] alu_a_s;
  logic [3:0]       alu_op_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_cout_s;
  logic [SHW-1:0]   amt_s;

  assign amt_s = B[SHW-1:0];

  // While shifting the datapath iterates on the held result; otherwise it sees the live inputs.
  always_comb begin
    if (state_q == ST_SHIFT) begin
      alu_a_s  = c_q;
      alu_op_s = op_q;
    end else begin
      alu_a_s  = A;
      alu_op_s = OP;
    end
  end

  alu_unit #(.WIDTH(WIDTH)) u_alu (
    .a    (alu_a_s),
    .b    (B),
    .cin  (Cin),
    .op   (alu_op_s),
    .res  (alu_res_s),
    .cout (alu_cout_s)
  );

  // Next-state, counter and result update.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = OP;
          if (is_shift_op(OP)) begin
            c_d    = A;
            cout_d = 1'b0;
            cnt_d  = amt_s;
            if (amt_s == {SHW{1'b0}}) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            c_d     = alu_res_s;
            cout_d  = alu_cout_s;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        c_d    = alu_res_s;
        cout_d = 1'b0;
        if (cnt_q != {SHW{1'b0}}) begin
          cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if (cnt_q <= {{(SHW-1){1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags follow the value that C will hold after the edge.
  always_comb begin
    zero_d = (c_d == {WIDTH{1'b0}});
    neg_d  = c_d[WIDTH-1];
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      c_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      cnt_q   <= {SHW{1'b0}};
      op_q    <= OP_ID;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign C         = c_q;
  assign Cout      = cout_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16) with hand-computed expected values.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [3:0]       OP;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             Cout;
  logic             Zero;
  logic             Neg;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .OP        (OP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .Cout      (Cout),
    .Zero      (Zero),
    .Neg       (Neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge; outputs are sampled 1 time unit later.
  task automatic accept(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    chk("pre_accept_in_ready", {31'd0, in_ready}, 32'd1);
    OP = op; A = a; B = b; Cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ret_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ret_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] c, input logic co, input logic z, input logic n);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_C"}, {16'd0, C}, {16'd0, c});
    chk({tag, "_Cout"}, {31'd0, Cout}, {31'd0, co});
    chk({tag, "_Zero"}, {31'd0, Zero}, {31'd0, z});
    chk({tag, "_Neg"}, {31'd0, Neg}, {31'd0, n});
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0000; B = 16'h0000; Cin = 1'b0; OP = OP_ID;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_C", {16'd0, C}, 32'd0);
    chk("rst_Cout", {31'd0, Cout}, 32'd0);
    chk("rst_Zero", {31'd0, Zero}, 32'd1);
    chk("rst_Neg", {31'd0, Neg}, 32'd0);
    #1 reset_n = 1'b1;

    // ADD on the very first edge after reset release
    accept(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    chk_res("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("add_in_ready", {31'd0, in_ready}, 32'd0);
    retire("add_wrap");

    accept(OP_SUB, 16'h0003, 16'h0003, 1'b1);
    chk_res("sub_borrow", 16'hFFFF, 1'b1, 1'b0, 1'b1);
    retire("sub_borrow");

    accept(OP_SUB, 16'h0005, 16'h0003, 1'b0);
    chk_res("sub_plain", 16'h0002, 1'b0, 1'b0, 1'b0);
    retire("sub_plain");

    accept(OP_ADD, 16'h7FFF, 16'h0000, 1'b1);
    chk_res("add_cin", 16'h8000, 1'b0, 1'b0, 1'b1);
    retire("add_cin");

    accept(OP_LHI, 16'h1234, 16'h12AB, 1'b1);
    chk_res("lhi", 16'hAB00, 1'b0, 1'b0, 1'b1);
    retire("lhi");

    accept(OP_NAND, 16'hFFFF, 16'h00FF, 1'b0);
    chk_res("nand", 16'hFF00, 1'b0, 1'b0, 1'b1);
    retire("nand");

    accept(OP_XOR, 16'h0F0F, 16'h00FF, 1'b0);
    chk_res("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    retire("xor");

    // ARS by 4: four busy cycles, result on the fifth edge counting the accept edge
    accept(OP_ARS, 16'h8000, 16'h0004, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("ars_busy_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ars_busy_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; OP = OP_ADD; A = 16'h1111; B = 16'h1111;
      tick();
      in_valid = 1'b0;
    end
    chk_res("ars4", 16'hF800, 1'b0, 1'b0, 1'b1);
    chk("ars_done_in_ready", {31'd0, in_ready}, 32'd0);
    retire("ars4");

    accept(OP_LRS, 16'hF000, 16'h0003, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("lrs_busy_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk_res("lrs3", 16'h1E00, 1'b0, 1'b0, 1'b0);
    retire("lrs3");

    accept(OP_ALR, 16'h8001, 16'h0000, 1'b0);
    chk_res("alr0", 16'h8001, 1'b0, 1'b0, 1'b1);
    retire("alr0");

    // RR by 1 with consumer stalled; new operations must be ignored
    accept(OP_RR, 16'h0001, 16'h0001, 1'b0);
    chk("rr_busy_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_res("rr1", 16'h8000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; OP = OP_ADD; A = 16'h0001; B = 16'h0001;
      tick();
      chk_res("rr1_stall", 16'h8000, 1'b0, 1'b0, 1'b1);
      chk("rr1_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    retire("rr1");

    // Reset in the middle of a long shift discards the operation
    accept(OP_ALS, 16'h0001, 16'h000F, 1'b0);
    tick(); tick(); tick();
    chk("als_busy_out_valid", {31'd0, out_valid}, 32'd0);
    reset_n = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_C", {16'd0, C}, 32'd0);
    chk("midrst_Zero", {31'd0, Zero}, 32'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("postrst_no_result", {31'd0, out_valid}, 32'd0);
    end

    accept(OP_OR, 16'h00F0, 16'h0F00, 1'b0);
    chk_res("or_after_rst", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    retire("or_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
